// File: rtl/pkt_slot_ram.sv
// Slot-organised packet buffer: byte-stream writes into a chosen slot,
// byte-stream reads with valid/ready backpressure, per-slot length/valid.
module pkt_slot_ram #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned SLOTS      = 16,
  parameter int unsigned SLOT_BYTES = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_start,
  input  logic [$clog2(SLOTS)-1:0]      wr_slot,
  input  logic                          wr_valid,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          wr_last,
  output logic                          wr_busy,
  output logic                          wr_done,
  output logic                          wr_err,
  input  logic                          rd_start,
  input  logic [$clog2(SLOTS)-1:0]      rd_slot,
  input  logic                          rd_consume,
  output logic                          rd_valid,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          rd_last,
  input  logic                          rd_ready,
  output logic                          rd_busy,
  output logic                          rd_err,
  output logic [SLOTS-1:0]              slot_valid
);

  localparam int unsigned SLOT_W    = $clog2(SLOTS);
  localparam int unsigned ADDR_W    = $clog2(SLOT_BYTES);
  localparam int unsigned LEN_W     = $clog2(SLOT_BYTES + 1);
  localparam int unsigned MEM_AW    = SLOT_W + ADDR_W;
  localparam int unsigned MEM_DEPTH = 1 << MEM_AW;

  typedef enum logic {W_IDLE = 1'b0, W_BUSY = 1'b1} wstate_t;
  typedef enum logic {R_IDLE = 1'b0, R_STREAM = 1'b1} rstate_t;

  logic [DATA_W-1:0] r_mem [MEM_DEPTH];

  wstate_t           r_wstate;
  logic [SLOT_W-1:0] r_wslot;
  logic [LEN_W-1:0]  r_wptr;
  logic              r_ovf;
  logic              r_wr_done;
  logic              r_wr_err;

  rstate_t           r_rstate;
  logic [SLOT_W-1:0] r_rslot;
  logic [ADDR_W-1:0] r_rptr;
  logic [LEN_W-1:0]  r_rem;
  logic              r_consume;
  logic              r_rd_valid;
  logic              r_rd_last;
  logic              r_rd_err;
  logic [DATA_W-1:0] r_rd_data;

  logic [SLOTS-1:0]  r_slot_valid;
  logic [LEN_W-1:0]  r_len [SLOTS];

  logic              w_rd_accept;
  logic              w_rd_reject;
  logic              w_wr_conflict;
  logic              w_wr_accept;
  logic              w_wr_reject;
  logic              w_wr_room;
  logic              w_mem_we;
  logic              w_wr_end;
  logic              w_commit;
  logic              w_fetch;
  logic              w_rd_hs_last;
  logic              w_consume_clr;
  logic              w_re;
  logic [LEN_W-1:0]  w_start_len;
  logic [MEM_AW-1:0] w_waddr;
  logic [MEM_AW-1:0] w_raddr;

  // Start arbitration, write-beat qualification and read fetch enables.
  always_comb begin
    w_rd_accept   = rd_start && (r_rstate == R_IDLE) && r_slot_valid[rd_slot];
    w_rd_reject   = rd_start && (r_rstate == R_IDLE) && !r_slot_valid[rd_slot];
    // A write may not open a slot being streamed out, nor one whose read wins this cycle.
    w_wr_conflict = ((r_rstate == R_STREAM) && (wr_slot == r_rslot)) ||
                    (w_rd_accept && (wr_slot == rd_slot));
    w_wr_accept   = wr_start && (r_wstate == W_IDLE) && !w_wr_conflict;
    w_wr_reject   = wr_start && (r_wstate == W_IDLE) && w_wr_conflict;
    w_wr_room     = r_wptr < LEN_W'(SLOT_BYTES);
    w_mem_we      = (r_wstate == W_BUSY) && wr_valid && w_wr_room;
    w_wr_end      = (r_wstate == W_BUSY) && wr_valid && wr_last;
    // The final beat must itself fit, otherwise the packet is truncated.
    w_commit      = w_wr_end && !r_ovf && w_wr_room;
    w_fetch       = (r_rstate == R_STREAM) && (r_rem != '0) && (!r_rd_valid || rd_ready);
    w_rd_hs_last  = r_rd_valid && rd_ready && r_rd_last;
    w_consume_clr = w_rd_hs_last && r_consume;
    w_re          = w_rd_accept || w_fetch;
    w_start_len   = r_len[rd_slot];
    w_waddr       = {r_wslot, r_wptr[ADDR_W-1:0]};
    // The first byte is fetched on the accepting edge to give 1-cycle latency.
    w_raddr       = w_rd_accept ? {rd_slot, ADDR_W'(0)} : {r_rslot, r_rptr};
  end

  // Payload storage: one write port, one registered read port.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_waddr] <= wr_data;
    if (w_re)     r_rd_data      <= r_mem[w_raddr];
  end

  // Write FSM: byte pointer, overflow tracking, done/err pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wstate  <= W_IDLE;
      r_wslot   <= '0;
      r_wptr    <= '0;
      r_ovf     <= 1'b0;
      r_wr_done <= 1'b0;
      r_wr_err  <= 1'b0;
    end else begin
      r_wr_done <= 1'b0;
      r_wr_err  <= w_wr_reject;
      case (r_wstate)
        W_IDLE: begin
          if (w_wr_accept) begin
            r_wstate <= W_BUSY;
            r_wslot  <= wr_slot;
            r_wptr   <= '0;
            r_ovf    <= 1'b0;
          end
        end
        W_BUSY: begin
          if (wr_valid) begin
            if (w_wr_room) r_wptr <= r_wptr + LEN_W'(1);
            else           r_ovf  <= 1'b1;
            if (wr_last) begin
              r_wstate  <= W_IDLE;
              r_wr_done <= w_commit;
              r_wr_err  <= !w_commit;
            end
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // Read FSM: remaining count, read pointer and output beat register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rstate   <= R_IDLE;
      r_rslot    <= '0;
      r_rptr     <= '0;
      r_rem      <= '0;
      r_consume  <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_rd_err   <= 1'b0;
    end else begin
      r_rd_err <= w_rd_reject;
      case (r_rstate)
        R_IDLE: begin
          if (w_rd_accept) begin
            r_rstate   <= R_STREAM;
            r_rslot    <= rd_slot;
            r_consume  <= rd_consume;
            r_rptr     <= ADDR_W'(1);
            r_rem      <= w_start_len - LEN_W'(1);
            r_rd_valid <= 1'b1;
            r_rd_last  <= (w_start_len == LEN_W'(1));
          end
        end
        R_STREAM: begin
          if (w_fetch) begin
            r_rd_valid <= 1'b1;
            r_rd_last  <= (r_rem == LEN_W'(1));
            r_rptr     <= r_rptr + ADDR_W'(1);
            r_rem      <= r_rem - LEN_W'(1);
          end else if (r_rd_valid && rd_ready) begin
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
          end
          if (w_rd_hs_last) r_rstate <= R_IDLE;
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  // Per-slot valid flags and committed lengths.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot_valid <= '0;
      for (int i = 0; i < int'(SLOTS); i++) r_len[i] <= '0;
    end else begin
      if (w_wr_accept) r_slot_valid[wr_slot] <= 1'b0;
      if (w_commit) begin
        r_slot_valid[r_wslot] <= 1'b1;
        r_len[r_wslot]        <= r_wptr + LEN_W'(1);
      end
      if (w_consume_clr) r_slot_valid[r_rslot] <= 1'b0;
    end
  end

  assign wr_busy    = (r_wstate == W_BUSY);
  assign wr_done    = r_wr_done;
  assign wr_err     = r_wr_err;
  assign rd_valid   = r_rd_valid;
  assign rd_data    = r_rd_data;
  assign rd_last    = r_rd_last;
  assign rd_busy    = (r_rstate == R_STREAM);
  assign rd_err     = r_rd_err;
  assign slot_valid = r_slot_valid;

endmodule
